// File: rtl/jtframe_uart_pkg.sv
// Shared constants, formatter state encoding and nibble-to-ASCII helper
// for the UART hex text formatter.
package jtframe_uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DIGIT,
        ST_SEP,
        ST_CR,
        ST_LF
    } state_t;

    // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/jtframe_uart_txpace.sv
// Byte pacer in front of the UART transmitter: one tx_wr strobe per accepted
// request, never while tx_busy is high nor in the cycle after a strobe.
module jtframe_uart_txpace (
    input  logic       rst,
    input  logic       clk,
    input  logic       req,
    input  logic [7:0] req_data,
    output logic       ack,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy
);

    // The gap after a strobe hides the one-cycle latency of tx_busy rising.
    assign ack = req & ~tx_busy & ~tx_wr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr   <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_wr <= ack;
            if (ack) tx_data <= req_data;
        end
    end

endmodule

// File: rtl/jtframe_uart_hexfmt.sv
// Formats binary words as uppercase hex text lines for the UART transmitter.
// Optional line index prefix "XXXX: " enabled by JTFRAME_UART_HEXFMT_ADDR_EN.
module jtframe_uart_hexfmt #(
    parameter int         NIBBLES        = 4,
    parameter int         WORDS_PER_LINE = 8,
    parameter logic [7:0] SEP            = 8'h20
)(
    input  logic                 rst,
    input  logic                 clk,
    input  logic [4*NIBBLES-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 flush,
    output logic [7:0]           tx_data,
    output logic                 tx_wr,
    input  logic                 tx_busy,
    output logic                 idle
);
    import jtframe_uart_pkg::*;

    localparam int         DW        = 4 * NIBBLES;
    localparam logic [2:0] LAST_NIB  = 3'(NIBBLES - 1);
    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);

    state_t          state, state_nxt;
    logic [2:0]      pos, pos_nxt;
    logic [7:0]      count, count_nxt;
    logic [DW-1:0]   word_q, word_nxt;
    logic            flush_pend, flush_clr;
    logic            req, ack;
    logic [7:0]      req_data;
    logic            transfer;

`ifdef JTFRAME_UART_HEXFMT_ADDR_EN
    logic [15:0]     word_idx, addr_q, addr_nxt;
`endif

    assign transfer = din_valid & din_ready;
    assign idle     = (state == ST_IDLE) & ~flush_pend & ~tx_wr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pos        <= 3'd0;
            count      <= 8'd0;
            word_q     <= '0;
            flush_pend <= 1'b0;
`ifdef JTFRAME_UART_HEXFMT_ADDR_EN
            word_idx   <= 16'd0;
            addr_q     <= 16'd0;
`endif
        end else begin
            state      <= state_nxt;
            pos        <= pos_nxt;
            count      <= count_nxt;
            word_q     <= word_nxt;
            // A new request in the same cycle as a clear stays pending
            flush_pend <= flush | (flush_pend & ~flush_clr);
`ifdef JTFRAME_UART_HEXFMT_ADDR_EN
            if (transfer) word_idx <= word_idx + 16'd1;
            addr_q     <= addr_nxt;
`endif
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        count_nxt = count;
        word_nxt  = word_q;
        flush_clr = 1'b0;
        din_ready = 1'b0;
        req       = 1'b0;
        req_data  = SEP;
`ifdef JTFRAME_UART_HEXFMT_ADDR_EN
        addr_nxt  = addr_q;
`endif
        case (state)
            ST_IDLE: begin
                din_ready = ~rst & ~flush_pend;
                if (flush_pend) begin
                    flush_clr = 1'b1;
                    if (count != 8'd0) begin
                        count_nxt = 8'd0;
                        state_nxt = ST_CR;
                    end
                end else if (din_valid) begin
                    word_nxt = din;
                    pos_nxt  = 3'd0;
`ifdef JTFRAME_UART_HEXFMT_ADDR_EN
                    if (count == 8'd0) begin
                        addr_nxt  = word_idx;
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_DIGIT;
                    end
`else
                    state_nxt = ST_DIGIT;
`endif
                end
            end
`ifdef JTFRAME_UART_HEXFMT_ADDR_EN
            ST_ADDR: begin
                req = 1'b1;
                if (pos < 3'd4)       req_data = hex_char(addr_q[15:12]);
                else if (pos == 3'd4) req_data = ASCII_COLON;
                else                  req_data = ASCII_SPACE;
                if (ack) begin
                    addr_nxt = addr_q << 4;
                    if (pos == 3'd5) begin
                        pos_nxt   = 3'd0;
                        state_nxt = ST_DIGIT;
                    end else begin
                        pos_nxt = pos + 3'd1;
                    end
                end
            end
`endif
            ST_DIGIT: begin
                req      = 1'b1;
                req_data = hex_char(word_q[DW-1 -: 4]);
                if (ack) begin
                    word_nxt = word_q << 4;
                    if (pos == LAST_NIB) begin
                        pos_nxt = 3'd0;
                        if (count == LAST_WORD) begin
                            count_nxt = 8'd0;
                            state_nxt = ST_CR;
                        end else begin
                            count_nxt = count + 8'd1;
                            state_nxt = ST_SEP;
                        end
                    end else begin
                        pos_nxt = pos + 3'd1;
                    end
                end
            end
            ST_SEP: begin
                req      = 1'b1;
                req_data = SEP;
                if (ack) state_nxt = ST_IDLE;
            end
            ST_CR: begin
                req      = 1'b1;
                req_data = ASCII_CR;
                if (ack) state_nxt = ST_LF;
            end
            ST_LF: begin
                req      = 1'b1;
                req_data = ASCII_LF;
                if (ack) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    jtframe_uart_txpace u_txpace (
        .rst      (rst),
        .clk      (clk),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

endmodule
